// File: rtl/if_stage_if.sv
// Fetch-stage boundary bundle: decode handshake, branch/exception redirect inputs and the
// instruction-SRAM request/response channel. The master side is the fetch stage itself.
interface if_stage_if #(
  parameter int unsigned FS_TO_DS_BUS_WD = 65
);
  // Decode side
  logic                       ds_allowin;
  logic [32:0]                br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

  // Write-back redirect
  logic                       handle_ex;
  logic [31:0]                ex_pc;

  // Instruction SRAM
  logic                       inst_sram_req;
  logic [31:0]                inst_sram_addr;
  logic                       inst_sram_addr_ok;
  logic                       inst_sram_data_ok;
  logic [31:0]                inst_sram_rdata;

  modport master (
    input  ds_allowin,
    input  br_bus,
    input  handle_ex,
    input  ex_pc,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    input  inst_sram_rdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output inst_sram_req,
    output inst_sram_addr
  );

  modport slave (
    output ds_allowin,
    output br_bus,
    output handle_ex,
    output ex_pc,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    output inst_sram_rdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  inst_sram_req,
    input  inst_sram_addr
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. Keeps at most one instruction-SRAM read in flight, hands
// {ex, inst, pc} to decode under valid/allowin, applies taken branches after the delay slot
// and redirects to ex_pc + 4 on an exception/eret flush, dropping any fetch still in flight.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter int unsigned FS_TO_DS_BUS_WD = 65
) (
  input logic        clk,
  input logic        resetn,
  if_stage_if.master fs
);

  typedef enum logic [1:0] {
    StReq,   // presenting npc to the SRAM (or raising ADEL for a misaligned npc)
    StWait,  // request accepted, waiting for read data
    StOut,   // instruction held on the bus until decode takes it
    StDrop   // flushed while a read was in flight; swallow its data
  } state_e;

  state_e                     state_q, state_d;
  logic [31:0]                npc_q, npc_d;
  logic [31:0]                cur_pc_q, cur_pc_d;
  logic [31:0]                br_tgt_q, br_tgt_d;
  logic                       br_seen_q, br_seen_d;
  logic                       br_pend_q, br_pend_d;
  logic                       fs_valid_q, fs_valid_d;
  logic [FS_TO_DS_BUS_WD-1:0] fs_bus_q, fs_bus_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        npc_aligned;
  logic        req_raw;
  logic        addr_acc;
  logic        adel;
  logic        br_hit;
  logic        npc_consumed;
  logic [31:0] seq_npc;

  assign br_taken    = fs.br_bus[32];
  assign br_target   = fs.br_bus[31:0];
  assign npc_aligned = (npc_q[1:0] == 2'b00);

  // A misaligned npc never reaches the SRAM; it is reported to decode as ADEL instead.
  assign req_raw  = (state_q == StReq) && npc_aligned;
  assign addr_acc = req_raw && fs.inst_sram_addr_ok;
  assign adel     = (state_q == StReq) && !npc_aligned;

  // Decode holds br_bus for as long as the branch sits there; act on it only once.
  assign br_hit = br_taken && !br_seen_q;

  // npc leaves StReq this cycle (delay slot is being fetched or faulted right now).
  assign npc_consumed = addr_acc || adel;

  // Address following the one being consumed: a pending branch target beats sequential.
  assign seq_npc = br_pend_q ? br_tgt_q : (npc_q + 32'd4);

  assign fs.inst_sram_req  = resetn && req_raw;
  assign fs.inst_sram_addr = npc_q;
  assign fs.fs_to_ds_valid = fs_valid_q;
  assign fs.fs_to_ds_bus   = fs_bus_q;

  // Next-state, redirect and output-bus staging.
  always_comb begin
    state_d    = state_q;
    npc_d      = npc_q;
    cur_pc_d   = cur_pc_q;
    br_tgt_d   = br_tgt_q;
    br_seen_d  = br_seen_q;
    br_pend_d  = br_pend_q;
    fs_valid_d = fs_valid_q;
    fs_bus_d   = fs_bus_q;

    if (fs.handle_ex) begin
      // Flush: everything in the stage is stale, only the redirect survives.
      npc_d      = fs.ex_pc + 32'd4;
      br_pend_d  = 1'b0;
      br_seen_d  = 1'b0;
      fs_valid_d = 1'b0;
      unique case (state_q)
        StReq:   state_d = addr_acc ? StDrop : StReq;
        StWait:  state_d = fs.inst_sram_data_ok ? StReq : StDrop;
        StOut:   state_d = StReq;
        StDrop:  state_d = fs.inst_sram_data_ok ? StReq : StDrop;
        default: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (adel) begin
            fs_bus_d   = {1'b1, 32'h0000_0000, npc_q};
            fs_valid_d = 1'b1;
            npc_d      = seq_npc;
            br_pend_d  = 1'b0;
            state_d    = StOut;
          end else if (addr_acc) begin
            cur_pc_d  = npc_q;
            npc_d     = seq_npc;
            br_pend_d = 1'b0;
            state_d   = StWait;
          end
        end
        StWait: begin
          if (fs.inst_sram_data_ok) begin
            fs_bus_d   = {1'b0, fs.inst_sram_rdata, cur_pc_q};
            fs_valid_d = 1'b1;
            state_d    = StOut;
          end
        end
        StOut: begin
          if (fs.ds_allowin) begin
            fs_valid_d = 1'b0;
            state_d    = StReq;
          end
        end
        StDrop: begin
          if (fs.inst_sram_data_ok) begin
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase

      if (br_hit) begin
        br_seen_d = 1'b1;
        if ((state_q == StReq) && !npc_consumed) begin
          // Delay slot not fetched yet: redirect once its address has been consumed.
          br_pend_d = 1'b1;
          br_tgt_d  = br_target;
        end else begin
          // Delay slot already fetched (or being fetched now): npc is the next target.
          npc_d = br_target;
        end
      end

      // A new instruction enters decode, so the next branch there is a fresh one.
      if ((state_q == StOut) && fs.ds_allowin) begin
        br_seen_d = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StReq;
      npc_q      <= RESET_PC;
      cur_pc_q   <= 32'h0000_0000;
      br_tgt_q   <= 32'h0000_0000;
      br_seen_q  <= 1'b0;
      br_pend_q  <= 1'b0;
      fs_valid_q <= 1'b0;
      fs_bus_q   <= '0;
    end else begin
      state_q    <= state_d;
      npc_q      <= npc_d;
      cur_pc_q   <= cur_pc_d;
      br_tgt_q   <= br_tgt_d;
      br_seen_q  <= br_seen_d;
      br_pend_q  <= br_pend_d;
      fs_valid_q <= fs_valid_d;
      fs_bus_q   <= fs_bus_d;
    end
  end

endmodule
